// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: sequencer state encoding, default timing
// divisors, digit indices and the per-cycle button edge bundle.
package stopwatch_ctrl_pkg;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_EDIT = 2'd2;

  typedef enum logic [1:0] {
    S_STOP = ST_STOP,
    S_RUN  = ST_RUN,
    S_EDIT = ST_EDIT
  } sw_state_e;

  // 100 MHz clock: 10 ms count tick, 250 ms blink half-period
  localparam int unsigned TICK_DIV_DEF  = 1000000;
  localparam int unsigned BLINK_DIV_DEF = 25000000;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [1:0]  DIG_10MS   = 2'd0;
  localparam logic [1:0]  DIG_100MS  = 2'd1;
  localparam logic [1:0]  DIG_1S     = 2'd2;
  localparam logic [1:0]  DIG_10S    = 2'd3;

  // One-cycle rising-edge flags of the four buttons
  typedef struct packed {
    logic start_stop;
    logic set;
    logic change;
    logic clear;
  } btn_edges_t;

  // Blanking mask selecting one digit
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] sel);
    logic [NUM_DIGITS-1:0] mask;
    mask = NUM_DIGITS'(1) << sel;
    return mask;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch sequencer.
//   master : button source / display+counter consumer (drives *_i)
//   slave  : stopwatch_ctrl (drives *_o)
interface stopwatch_ctrl_if;

  logic       start_stop_i;
  logic       set_i;
  logic       change_i;
  logic       clear_i;
  logic       tick_10ms_o;
  logic       cnt_clr_o;
  logic [1:0] digit_sel_o;
  logic       digit_inc_o;
  logic [3:0] blank_o;
  logic [1:0] state_o;

  modport master (
    output start_stop_i, set_i, change_i, clear_i,
    input  tick_10ms_o, cnt_clr_o, digit_sel_o, digit_inc_o, blank_o, state_o
  );

  modport slave (
    input  start_stop_i, set_i, change_i, clear_i,
    output tick_10ms_o, cnt_clr_o, digit_sel_o, digit_inc_o, blank_o, state_o
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: 2-FF synchronizer followed by a rising-edge detector.
//   clk, rst : clock, async active-high reset
//   btn      : asynchronous debounced button level
//   rise_c   : combinational one-cycle pulse on a synchronized 0->1 change
// All flops reset to 1 so a button held through reset never fires.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_c
);

  logic [1:0] sync_q;
  logic       hist_q;

  // Synchronizer and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn};
      hist_q <= sync_q[1];
    end
  end

  // Combinational so the FSM registers the action on the 3rd edge
  assign rise_c = sync_q[1] & ~hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: STOP/RUN/EDIT sequencer for the 4-digit stopwatch.
// Generates the 10 ms count tick, counter clear, digit-edit controls and a
// per-digit blink mask. All outputs are registered.
//   clk100_i : 100 MHz clock
//   rst_i    : async active-high reset
//   bus      : buttons in, tick/clear/edit/blank/state out
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  btn_edges_t raw_c;
  btn_edges_t ev_c;

  sw_state_e             state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic                  tick_q, tick_d;
  logic                  clr_q, clr_d;
  logic                  inc_q, inc_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  btn_edge u_edge_ss  (.clk(clk100_i), .rst(rst_i), .btn(bus.start_stop_i), .rise_c(raw_c.start_stop));
  btn_edge u_edge_set (.clk(clk100_i), .rst(rst_i), .btn(bus.set_i),        .rise_c(raw_c.set));
  btn_edge u_edge_chg (.clk(clk100_i), .rst(rst_i), .btn(bus.change_i),     .rise_c(raw_c.change));
  btn_edge u_edge_clr (.clk(clk100_i), .rst(rst_i), .btn(bus.clear_i),      .rise_c(raw_c.clear));

  // Fixed priority: start_stop > set > change > clear
  always_comb begin
    ev_c            = '0;
    ev_c.start_stop = raw_c.start_stop;
    ev_c.set        = raw_c.set & ~raw_c.start_stop;
    ev_c.change     = raw_c.change & ~raw_c.set & ~raw_c.start_stop;
    ev_c.clear      = raw_c.clear & ~raw_c.change & ~raw_c.set & ~raw_c.start_stop;
  end

  // State and datapath registers
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_STOP;
      sel_q   <= DIG_10MS;
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      inc_q   <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      inc_q   <= inc_d;
      blank_q <= blank_d;
    end
  end

  // Next-state, prescaler, blink and pulse generation
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    inc_d   = 1'b0;

    unique case (state_q)
      S_STOP: begin
        if (ev_c.start_stop) begin
          state_d = S_RUN;
        end else if (ev_c.set) begin
          state_d = S_EDIT;
          sel_d   = DIG_10MS;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end else if (ev_c.clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end
      S_RUN: begin
        // Leaving RUN holds the prescaler phase and suppresses the tick
        if (ev_c.start_stop) begin
          state_d = S_STOP;
        end else if (ev_c.clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (presc_q == TICK_MAX) begin
          tick_d  = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_EDIT: begin
        if (ev_c.start_stop) begin
          state_d = S_STOP;
          sel_d   = DIG_10MS;
        end else if (ev_c.set) begin
          bcnt_d  = '0;
          phase_d = 1'b0;
          if (sel_q == DIG_10S) begin
            state_d = S_STOP;
            sel_d   = DIG_10MS;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else if (ev_c.change) begin
          inc_d   = 1'b1;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end else if (bcnt_q == BLINK_MAX) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = S_STOP;
        sel_d   = DIG_10MS;
      end
    endcase

    blank_d = (state_d == S_EDIT && phase_d) ? digit_onehot(sel_d) : '0;
  end

  assign bus.state_o     = state_q;
  assign bus.digit_sel_o = sel_q;
  assign bus.tick_10ms_o = tick_q;
  assign bus.cnt_clr_o   = clr_q;
  assign bus.digit_inc_o = inc_q;
  assign bus.blank_o     = blank_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV = 4, BLINK_DIV = 6).
// Expected output events (cycle + full output vector) are queued in cycle
// order; a monitor pops one whenever the DUT shows a pulse or a change of
// state/digit/blank, and flags missed or unexpected events.
module tb_stopwatch_ctrl;

  localparam logic [3:0] B_SS  = 4'b0001;
  localparam logic [3:0] B_SET = 4'b0010;
  localparam logic [3:0] B_CHG = 4'b0100;
  localparam logic [3:0] B_CLR = 4'b1000;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] sel;
    logic [3:0] blank;
    logic       tick;
    logic       clr;
    logic       inc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  ev_t  q[$];
  ev_t  mon_e;
  logic [7:0] prev_static;
  logic [7:0] cur_static;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4), .BLINK_DIV(6)) dut (
    .clk100_i (clk),
    .rst_i    (rst),
    .bus      (sw_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else passed++;
  endtask

  // Sorted insert keeps the queue in cycle order
  task automatic exp_ev(input int c, input logic [1:0] st, input logic [1:0] sel,
                        input logic [3:0] bl, input logic t, input logic cl, input logic in);
    ev_t e;
    int  pos;
    e.cyc = c; e.st = st; e.sel = sel; e.blank = bl; e.tick = t; e.clr = cl; e.inc = in;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    sw_if.start_stop_i = m[0];
    sw_if.set_i        = m[1];
    sw_if.change_i     = m[2];
    sw_if.clear_i      = m[3];
  endtask

  // Button high for 2 cycles from cycle 'at'; action lands on cycle at+3
  task automatic press(input logic [3:0] m, input int at);
    wait_until(at);
    set_btns(m);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    set_btns(4'b0000);
  endtask

  // Monitor
  initial begin
    prev_static = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_static = '0;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          $display("FAIL missed_event expected_cyc=%0d now=%0d st=%0d sel=%0d blank=%b t/c/i=%b%b%b",
                   q[0].cyc, cyc, q[0].st, q[0].sel, q[0].blank, q[0].tick, q[0].clr, q[0].inc);
          void'(q.pop_front());
        end
        cur_static = {sw_if.state_o, sw_if.digit_sel_o, sw_if.blank_o};
        if (cur_static != prev_static || sw_if.tick_10ms_o || sw_if.cnt_clr_o || sw_if.digit_inc_o) begin
          checks++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_event cyc=%0d st=%0d sel=%0d blank=%b t/c/i=%b%b%b", cyc,
                     sw_if.state_o, sw_if.digit_sel_o, sw_if.blank_o,
                     sw_if.tick_10ms_o, sw_if.cnt_clr_o, sw_if.digit_inc_o);
          end else begin
            mon_e = q.pop_front();
            if (mon_e.cyc != cyc || mon_e.st !== sw_if.state_o || mon_e.sel !== sw_if.digit_sel_o ||
                mon_e.blank !== sw_if.blank_o || mon_e.tick !== sw_if.tick_10ms_o ||
                mon_e.clr !== sw_if.cnt_clr_o || mon_e.inc !== sw_if.digit_inc_o) begin
              $display("FAIL event actual cyc=%0d st=%0d sel=%0d blank=%b t/c/i=%b%b%b required cyc=%0d st=%0d sel=%0d blank=%b t/c/i=%b%b%b",
                       cyc, sw_if.state_o, sw_if.digit_sel_o, sw_if.blank_o,
                       sw_if.tick_10ms_o, sw_if.cnt_clr_o, sw_if.digit_inc_o,
                       mon_e.cyc, mon_e.st, mon_e.sel, mon_e.blank, mon_e.tick, mon_e.clr, mon_e.inc);
            end else begin
              passed++;
            end
          end
        end
        prev_static = cur_static;
      end
    end
  end

  initial begin
    #30000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    set_btns(4'b0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then 20 idle cycles with no events
    wait_until(1);
    chk("rst_state", int'(sw_if.state_o), 0);
    chk("rst_sel", int'(sw_if.digit_sel_o), 0);
    chk("rst_blank", int'(sw_if.blank_o), 0);
    chk("rst_pulses", int'({sw_if.tick_10ms_o, sw_if.cnt_clr_o, sw_if.digit_inc_o}), 0);

    // Run, pause with prescaler at 3, resume (tick one cycle later), pause
    exp_ev(23, 2'd1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(27, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(31, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(35, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(41, 2'd1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(42, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(46, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(48, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    press(B_SS, 20);
    press(B_SS, 32);
    press(B_SS, 38);
    press(B_SS, 45);

    // Clear in STOP
    exp_ev(55, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    press(B_CLR, 52);

    // Edit walk: two increments, digits 1..3, exit to STOP
    exp_ev(61, 2'd2, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(65, 2'd2, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    exp_ev(69, 2'd2, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    exp_ev(73, 2'd2, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(77, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(81, 2'd2, 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(85, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 58);
    press(B_CHG, 62);
    press(B_CHG, 66);
    press(B_SET, 70);
    press(B_SET, 74);
    press(B_SET, 78);
    press(B_SET, 82);

    // start_stop+set together -> RUN only; clear in RUN; set ignored in RUN
    exp_ev(93,  2'd1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(97,  2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(101, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(103, 2'd1, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    exp_ev(107, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(111, 2'd1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
    exp_ev(113, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    press(B_SS | B_SET, 90);
    press(B_CLR, 100);
    press(B_SET, 104);
    press(B_SS, 110);

    // Blink on digit 2, change restarts phase, clear ignored in EDIT
    exp_ev(119, 2'd2, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(123, 2'd2, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(127, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(133, 2'd2, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b0);
    exp_ev(139, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(145, 2'd2, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b0);
    exp_ev(149, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b1);
    exp_ev(155, 2'd2, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b0);
    exp_ev(161, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
    exp_ev(165, 2'd2, 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 116);
    press(B_SET, 120);
    press(B_SET, 124);
    press(B_CHG, 146);
    press(B_CLR, 156);
    press(B_SET, 162);

    // Async reset mid-EDIT: outputs clear before the next clock edge
    wait_until(167);
    #2 rst = 1'b1;
    #1;
    chk("async_state", int'(sw_if.state_o), 0);
    chk("async_sel", int'(sw_if.digit_sel_o), 0);
    chk("async_blank", int'(sw_if.blank_o), 0);
    chk("async_pulses", int'({sw_if.tick_10ms_o, sw_if.cnt_clr_o, sw_if.digit_inc_o}), 0);

    // set held across reset release: no EDIT entry
    set_btns(B_SET);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 set_btns(4'b0000);
    repeat (10) @(posedge clk);
    #1;
    chk("held_set_state", int'(sw_if.state_o), 0);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Central sequencer for the 4-digit stopwatch datapath (10 ms, 100 ms, 1 s and 10 s digit counters plus the 7-segment decoders). It turns the four debounced buttons into a STOP/RUN/EDIT state machine and generates the 10 ms count tick. It also drives the digit-edit controls (digit select, increment strobe, clear strobe) and a per-digit blink mask for the display. All outputs are registered.

Parameters:
TICK_DIV, 1000000, clk100_i cycles per 10 ms tick; legal values are 2 or more.
BLINK_DIV, 25000000, clk100_i cycles per blink half-period (250 ms); legal values are 2 or more.

Ports:
clk100_i  in  1  system clock, 100 MHz
rst_i  in  1  asynchronous reset, active-high
start_stop_i  in  1  debounced button level, active-high
set_i  in  1  debounced button level, active-high
change_i  in  1  debounced button level, active-high
clear_i  in  1  debounced button level, active-high
tick_10ms_o  out  1  one-cycle count-enable pulse to the 10 ms digit counter
cnt_clr_o  out  1  one-cycle pulse; zeroes all four digit counters
digit_sel_o  out  2  digit under edit; 0 = 10 ms digit, 3 = 10 s digit
digit_inc_o  out  1  one-cycle pulse; selected digit increments mod 10
blank_o  out  4  per-digit blanking mask; bit i blanks digit i
state_o  out  2  0 = STOP, 1 = RUN, 2 = EDIT; encoding 3 is never output

Behaviour:
- Reset (async assert, sync release) sets: state STOP, digit_sel_o 0, all pulse outputs 0, blank_o 0, prescaler 0, blink counter 0, blink phase 0.
- Edge detection history flops reset to 1. A button held through reset therefore produces no action.
- Each button passes through a 2-FF synchronizer and a rising-edge detector.
- The resulting action appears on registered outputs at the 3rd rising clk edge, counting the edge that first samples the button high as the 1st.
- One action per press. Holding a button never repeats the action.
- Simultaneous edge priority: start_stop, then set, then change, then clear. Lower-priority edges in the same cycle are discarded.
- STOP state:
  - start_stop edge: go to RUN.
  - set edge: go to EDIT, digit_sel_o = 0.
  - clear edge: cnt_clr_o pulse; prescaler is zeroed.
  - change edge: ignored.
- RUN state:
  - start_stop edge: go to STOP.
  - clear edge: cnt_clr_o pulse, prescaler zeroed, stays in RUN.
  - set and change edges: ignored.
- EDIT state:
  - change edge: digit_inc_o pulse.
  - set edge with digit_sel_o < 3: digit_sel_o increments.
  - set edge with digit_sel_o = 3: go to STOP, digit_sel_o = 0.
  - start_stop edge: abort to STOP, digit_sel_o = 0.
  - clear edge: ignored.
- Prescaler:
  - Counts 0 .. TICK_DIV-1 only in RUN.
  - When it equals TICK_DIV-1, tick_10ms_o = 1 for one cycle and the prescaler wraps to 0.
  - Holds its value in STOP and EDIT, so a paused run resumes with phase preserved.
  - No tick is issued in the cycle the state leaves RUN.
- Blink:
  - Counter runs only in EDIT and toggles the blink phase at BLINK_DIV-1.
  - On entering EDIT, and on every set or change edge within EDIT, the counter and phase are zeroed (digit visible).
  - blank_o = one-hot(digit_sel_o) when in EDIT with phase 1, otherwise 0.
- cnt_clr_o, digit_inc_o and tick_10ms_o are never high for two consecutive cycles. At most one of them is high in any cycle.
- Reset mid-operation: all state is immediately forced to reset values, regardless of the clock.

Decomposition:
- Shared stopwatch package/include holds:
  - state encoding localparams ST_STOP = 2'd0, ST_RUN = 2'd1, ST_EDIT = 2'd2;
  - default TICK_DIV / BLINK_DIV constants;
  - digit index constants.
- One sub-module, btn_edge: 2-FF synchronizer plus rising-edge pulse, history reset to 1. It is instantiated 4 times.
- The FSM, prescaler and blink logic stay in stopwatch_ctrl.

Test Plan:
All scenarios run with TICK_DIV = 4 and BLINK_DIV = 6.
- Reset/idle: assert rst_i for 3 cycles, hold no buttons for 20 cycles after release -> state_o = 0, every output 0 throughout.
- Run/pause: start_stop press -> state_o = 1 at the 3rd edge; tick_10ms_o pulses every 4 cycles. Press start_stop again after prescaler = 2 -> state_o = 0. Resume -> first tick arrives 1 cycle after re-entering RUN.
- Edit walk: set press -> state_o = 2, digit_sel_o = 0. Two change presses -> exactly 2 digit_inc_o pulses. Four further set presses -> digit_sel_o goes 1, 2, 3, then state_o = 0 and digit_sel_o = 0.
- Blink: in EDIT with digit_sel_o = 2 and no presses -> blank_o alternates 4'b0000 / 4'b0100 every 6 cycles. A change press -> blank_o = 0 in the next cycle and the phase restarts.
- Priority/ignore: start_stop and set rise in the same cycle from STOP -> RUN only, digit_sel_o unchanged. Clear in EDIT -> no cnt_clr_o. Clear in RUN -> one cnt_clr_o pulse, state stays RUN, next tick arrives 4 cycles later.
- Reset robustness: set_i held high across reset release -> no EDIT entry. Assert rst_i mid-EDIT (digit_sel_o = 3) -> all outputs return to reset values asynchronously, before the next clk edge.
